// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Sequencer states, transaction owner, strobe width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    typedef enum logic {
        OWN_INSTR,
        OWN_DATA
    } owner_e;

    function automatic int strb_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Grant and conflict counters for the memory port arbiter.
// All counters are 32 bits and wrap naturally.
module mem_arb_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_grant,
    input  logic        d_grant,
    input  logic        conflict,
    output logic [31:0] perf_i_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_conflict_cycles
);

    logic [31:0] i_cnt_q, i_cnt_d;
    logic [31:0] d_cnt_q, d_cnt_d;
    logic [31:0] c_cnt_q, c_cnt_d;

    // Next-count for each event counter.
    always_comb begin
        i_cnt_d = i_cnt_q;
        d_cnt_d = d_cnt_q;
        c_cnt_d = c_cnt_q;
        if (i_grant) i_cnt_d = i_cnt_q + 32'd1;
        if (d_grant) d_cnt_d = d_cnt_q + 32'd1;
        if (conflict) c_cnt_d = c_cnt_q + 32'd1;
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_cnt_q <= '0;
            d_cnt_q <= '0;
            c_cnt_q <= '0;
        end else begin
            i_cnt_q <= i_cnt_d;
            d_cnt_q <= d_cnt_d;
            c_cnt_q <= c_cnt_d;
        end
    end

    assign perf_i_grants        = i_cnt_q;
    assign perf_d_grants        = d_cnt_q;
    assign perf_conflict_cycles = c_cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and the memory stage.
// Optional counters enabled by defining MEM_ARB_PERF_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req,
    input  logic [ADDRESS_WIDTH-1:0]  i_addr,
    input  logic                      flush_i,
    output logic                      i_rsp_valid,
    output logic [DATA_WIDTH-1:0]     i_rdata,
    output logic                      i_stall,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [ADDRESS_WIDTH-1:0]  d_addr,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    input  logic [DATA_WIDTH/8-1:0]   d_wstrb,
    output logic                      d_rsp_valid,
    output logic [DATA_WIDTH-1:0]     d_rdata,
    output logic                      d_stall,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDRESS_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic                      mem_we,
    output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
    input  logic                      mem_rsp_valid,
`ifdef MEM_ARB_PERF_EN
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic [31:0]               perf_i_grants,
    output logic [31:0]               perf_d_grants,
    output logic [31:0]               perf_conflict_cycles
`else
    input  logic [DATA_WIDTH-1:0]     mem_rdata
`endif
);

    localparam int STRB_WIDTH = strb_width(DATA_WIDTH);

    arb_state_e state_q, state_d;
    owner_e     owner_q, owner_d;
    logic       drop_q,  drop_d;

    logic [ADDRESS_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     we_q,    we_d;
    logic [STRB_WIDTH-1:0]    wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]    irdata_q, irdata_d;
    logic [DATA_WIDTH-1:0]    drdata_q, drdata_d;

    // Sequencer: grant, issue, wait for response, deliver.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        drop_d   = drop_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        wstrb_d  = wstrb_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        unique case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (d_req) begin
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    we_d    = d_we;
                    wstrb_d = d_wstrb;
                    owner_d = OWN_DATA;
                    state_d = ISSUE;
                end else if (i_req && !flush_i) begin
                    addr_d  = i_addr;
                    wdata_d = '0;
                    we_d    = 1'b0;
                    wstrb_d = '0;
                    owner_d = OWN_INSTR;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (owner_q == OWN_INSTR && flush_i) drop_d = 1'b1;
                if (mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (owner_q == OWN_INSTR && flush_i) drop_d = 1'b1;
                if (mem_rsp_valid) begin
                    if (owner_q == OWN_INSTR) irdata_d = mem_rdata;
                    else drdata_d = mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                drop_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                drop_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and latched request fields; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= OWN_INSTR;
            drop_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            wstrb_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            drop_q   <= drop_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            wstrb_q  <= wstrb_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    assign mem_req_valid = (state_q == ISSUE);
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_we        = we_q;
    assign mem_wstrb     = wstrb_q;

    assign i_rsp_valid = (state_q == RESP) && (owner_q == OWN_INSTR) && !drop_q;
    assign d_rsp_valid = (state_q == RESP) && (owner_q == OWN_DATA);
    assign i_rdata     = irdata_q;
    assign d_rdata     = drdata_q;

    assign i_stall = i_req && !i_rsp_valid && !flush_i;
    assign d_stall = d_req && !d_rsp_valid;

`ifdef MEM_ARB_PERF_EN
    logic i_grant;
    logic d_grant;

    assign d_grant = (state_q == IDLE) && d_req;
    assign i_grant = (state_q == IDLE) && !d_req && i_req && !flush_i;

    mem_arb_perf u_perf (
        .clk                  (clk),
        .rst                  (rst),
        .i_grant              (i_grant),
        .d_grant              (d_grant),
        .conflict             (i_stall && d_req),
        .perf_i_grants        (perf_i_grants),
        .perf_d_grants        (perf_d_grants),
        .perf_conflict_cycles (perf_conflict_cycles)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural memory.
// Counter checks are compiled in when MEM_ARB_PERF_EN is defined.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        flush_i;
    logic        i_rsp_valid;
    logic [31:0] i_rdata;
    logic        i_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_rsp_valid;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_i_grants;
    logic [31:0] perf_d_grants;
    logic [31:0] perf_conflict_cycles;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .flush_i       (flush_i),
        .i_rsp_valid   (i_rsp_valid),
        .i_rdata       (i_rdata),
        .i_stall       (i_stall),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_wstrb       (d_wstrb),
        .d_rsp_valid   (d_rsp_valid),
        .d_rdata       (d_rdata),
        .d_stall       (d_stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_wstrb     (mem_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
`ifdef MEM_ARB_PERF_EN
        .mem_rdata            (mem_rdata),
        .perf_i_grants        (perf_i_grants),
        .perf_d_grants        (perf_d_grants),
        .perf_conflict_cycles (perf_conflict_cycles)
`else
        .mem_rdata     (mem_rdata)
`endif
    );

    typedef struct {
        bit          instr;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [31:0] wd;
        logic [3:0]  ws;
    } acc_t;

    exp_t exp_q[$];
    acc_t acc_q[$];
    exp_t e;
    logic [31:0] marr [logic [31:0]];
    logic [31:0] mw;
    logic [31:0] rsp_data;

    int errs = 0;
    int chks = 0;
    int ready_delay = 0;
    int rsp_lat = 1;
    int wait_cnt = 0;
    int rsp_cd = 0;
    int issue_cyc = 0;
    bit chk_fields = 1'b0;
    logic [31:0] ef_addr;
    logic        ef_we;
    logic [31:0] ef_wdata;
    logic [3:0]  ef_wstrb;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: optional ready back-pressure, fixed response latency.
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        forever begin
            @(negedge clk);
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (rst) begin
                wait_cnt = 0;
                rsp_cd   = 0;
            end else if (rsp_cd > 0) begin
                rsp_cd--;
                if (rsp_cd == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata     = rsp_data;
                end
            end else if (mem_req_valid) begin
                if (wait_cnt < ready_delay) begin
                    wait_cnt++;
                end else begin
                    mem_req_ready = 1'b1;
                    wait_cnt = 0;
                    acc_q.push_back('{mem_addr, mem_we, mem_wdata, mem_wstrb});
                    mw = marr.exists(mem_addr) ? marr[mem_addr] : 32'h0;
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b]) mw[8*b +: 8] = mem_wdata[8*b +: 8];
                        marr[mem_addr] = mw;
                        rsp_data = 32'h0;
                    end else begin
                        rsp_data = mw;
                    end
                    rsp_cd = rsp_lat;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every response pulse.
    always @(negedge clk) begin
        if (i_rsp_valid && d_rsp_valid) begin
            chks++;
            errs++;
            $display("FAIL both_rsp: i and d rsp_valid together");
        end else if (i_rsp_valid || d_rsp_valid) begin
            if (exp_q.size() == 0) begin
                chks++;
                errs++;
                $display("FAIL unexpected_rsp: i=%0b d=%0b with empty queue",
                         i_rsp_valid, d_rsp_valid);
            end else begin
                e = exp_q.pop_front();
                check("rsp_owner_instr", {31'b0, i_rsp_valid}, {31'b0, e.instr});
                if (e.chk && e.instr) check("i_rdata", i_rdata, e.data);
                if (e.chk && !e.instr) check("d_rdata", d_rdata, e.data);
            end
        end
        if (chk_fields && mem_req_valid) begin
            issue_cyc++;
            check("held_addr", mem_addr, ef_addr);
            check("held_we", {31'b0, mem_we}, {31'b0, ef_we});
            check("held_wdata", mem_wdata, ef_wdata);
            check("held_wstrb", {28'b0, mem_wstrb}, {28'b0, ef_wstrb});
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rsp(input bit instr, input int max, output int cyc);
        bit got;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < max) begin
            step();
            cyc++;
            if (instr) begin
                if (i_rsp_valid) begin
                    got = 1'b1;
                    check("i_stall_at_rsp", {31'b0, i_stall}, 32'd0);
                    i_req = 1'b0;
                end else begin
                    check("i_stall_wait", {31'b0, i_stall}, 32'd1);
                end
            end else begin
                if (d_rsp_valid) begin
                    got = 1'b1;
                    check("d_stall_at_rsp", {31'b0, d_stall}, 32'd0);
                    d_req = 1'b0;
                end else begin
                    check("d_stall_wait", {31'b0, d_stall}, 32'd1);
                end
                if (i_req) check("i_stall_behind_d", {31'b0, i_stall}, 32'd1);
            end
        end
        if (!got) begin
            chks++;
            errs++;
            $display("FAIL rsp_timeout: instr=%0b no response in %0d cycles",
                     instr, max);
        end
    endtask

    task automatic wait_accept(input int n);
        int k;
        k = 0;
        while (acc_q.size() < n && k < 20) begin
            step();
            k++;
        end
        check("accept_seen", acc_q.size(), n);
    endtask

    int c;
    int base;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] pi0, pd0, pc0;
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        i_req = 0; i_addr = 0; flush_i = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
        marr[32'h100] = 32'h00500093;
        marr[32'h104] = 32'h00A00113;
        marr[32'h108] = 32'h11111111;
        marr[32'h10C] = 32'h22222222;
        repeat (3) step();
        check("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("rst_i_rsp_valid", {31'b0, i_rsp_valid}, 32'd0);
        check("rst_d_rsp_valid", {31'b0, d_rsp_valid}, 32'd0);
        check("rst_i_stall", {31'b0, i_stall}, 32'd0);
        check("rst_d_stall", {31'b0, d_stall}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        rst = 1'b0;
        step();

        // Single fetch, ready at once, response one cycle after accept.
        base = acc_q.size();
        i_req = 1'b1;
        i_addr = 32'h100;
        exp_q.push_back('{1'b1, 1'b1, 32'h00500093});
        #1 check("fetch_i_stall_req", {31'b0, i_stall}, 32'd1);
        wait_rsp(1'b1, 20, c);
        check("fetch_latency", c, 3);
        check("fetch_acc_addr", acc_q[base].a, 32'h100);
        check("fetch_acc_we", {31'b0, acc_q[base].we}, 32'd0);
        step();
        check("fetch_i_rdata_hold", i_rdata, 32'h00500093);

        // Simultaneous fetch and store: store first.
`ifdef MEM_ARB_PERF_EN
        pi0 = perf_i_grants;
        pd0 = perf_d_grants;
        pc0 = perf_conflict_cycles;
`endif
        base = acc_q.size();
        i_req = 1'b1;
        i_addr = 32'h104;
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 32'h2000;
        d_wdata = 32'hDEADBEEF;
        d_wstrb = 4'b0011;
        exp_q.push_back('{1'b0, 1'b0, 32'h0});
        exp_q.push_back('{1'b1, 1'b1, 32'h00A00113});
        wait_rsp(1'b0, 20, c);
        check("store_latency", c, 3);
        d_we = 1'b0;
        wait_rsp(1'b1, 20, c);
        check("fetch_after_store_latency", c, 4);
        check("conf_acc0_addr", acc_q[base].a, 32'h2000);
        check("conf_acc0_we", {31'b0, acc_q[base].we}, 32'd1);
        check("conf_acc0_wdata", acc_q[base].wd, 32'hDEADBEEF);
        check("conf_acc0_wstrb", {28'b0, acc_q[base].ws}, 32'h3);
        check("conf_acc1_addr", acc_q[base+1].a, 32'h104);
        check("conf_acc1_we", {31'b0, acc_q[base+1].we}, 32'd0);
        check("conf_acc1_wstrb", {28'b0, acc_q[base+1].ws}, 32'h0);
`ifdef MEM_ARB_PERF_EN
        check("perf_d_grants", perf_d_grants - pd0, 32'd1);
        check("perf_i_grants", perf_i_grants - pi0, 32'd1);
        check("perf_conflict", perf_conflict_cycles - pc0, 32'd3);
`endif
        step();

        // Load with ready held low four cycles; fields held steady.
        ready_delay = 4;
        issue_cyc = 0;
        ef_addr = 32'h2000;
        ef_we = 1'b0;
        ef_wdata = 32'h12345678;
        ef_wstrb = 4'b0000;
        chk_fields = 1'b1;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h2000;
        d_wdata = 32'h12345678;
        d_wstrb = 4'b0000;
        exp_q.push_back('{1'b0, 1'b1, 32'h0000BEEF});
        wait_rsp(1'b0, 30, c);
        check("stall_load_latency", c, 7);
        check("stall_issue_cycles", issue_cyc, 5);
        chk_fields = 1'b0;
        ready_delay = 0;
        step();
        check("d_rdata_hold", d_rdata, 32'h0000BEEF);

        // Flush while fetch is in WAIT: response dropped, next fetch served.
        base = acc_q.size();
        rsp_lat = 3;
        i_req = 1'b1;
        i_addr = 32'h108;
        wait_accept(base + 1);
        step();
        flush_i = 1'b1;
        #1 check("flush_i_stall", {31'b0, i_stall}, 32'd0);
        step();
        flush_i = 1'b0;
        rsp_lat = 1;
        i_addr = 32'h10C;
        exp_q.push_back('{1'b1, 1'b1, 32'h22222222});
        wait_rsp(1'b1, 20, c);
        check("refetch_latency", c, 6);
        check("flush_acc0_addr", acc_q[base].a, 32'h108);
        check("flush_acc1_addr", acc_q[base+1].a, 32'h10C);
        step();

        // Reset in WAIT abandons a load.
        base = acc_q.size();
        rsp_lat = 5;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h2000;
        wait_accept(base + 1);
        step();
        rst = 1'b1;
        d_req = 1'b0;
        i_req = 1'b1;
        i_addr = 32'h100;
        #1;
        check("rst_mid_d_stall", {31'b0, d_stall}, 32'd0);
        check("rst_mid_i_stall", {31'b0, i_stall}, 32'd1);
        step();
        check("post_rst_valid", {31'b0, mem_req_valid}, 32'd0);
        check("post_rst_d_rsp", {31'b0, d_rsp_valid}, 32'd0);
        check("post_rst_d_rdata", d_rdata, 32'd0);
        check("post_rst_i_rdata", i_rdata, 32'd0);
        rst = 1'b0;
        rsp_lat = 1;
        exp_q.push_back('{1'b1, 1'b1, 32'h00500093});
        wait_rsp(1'b1, 20, c);
        check("post_rst_fetch_latency", c, 3);

        repeat (4) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
